// File: rtl/mul_writeback_unit.sv
// mul_writeback_unit
// Radix-2 shift-add multiplier that sits between the register-file read ports
// and the write port. It takes magnitudes of the operands and runs W add/shift
// steps. It then applies the sign and issues a single RegFile write-back.
module mul_writeback_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [DATA_WIDTH-1:0]    rs1_val,
  input  logic [DATA_WIDTH-1:0]    rs2_val,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] ad3,
  output logic [DATA_WIDTH-1:0]    wd3
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                   state_q;
  logic [1:0]               op_q;
  logic [ADDRESS_WIDTH-1:0] rd_q;
  logic                     neg_q;
  logic [CW-1:0]            count_q;
  logic [2*W-1:0]           mcand_q;
  logic [W-1:0]             mplier_q;
  logic [2*W-1:0]           prod_q;

  logic                     aNeg_d;
  logic                     bNeg_d;
  logic [W-1:0]             aMag_d;
  logic [W-1:0]             bMag_d;
  logic                     neg_d;
  logic [2*W-1:0]           prodStep_d;
  logic [2*W-1:0]           prodSigned_d;

  // Operand magnitudes and result sign. Only operands treated as signed by the
  // op code can contribute a sign. The most negative value negates to itself.
  // Read as unsigned, that is exactly its magnitude.
  always_comb begin
    aNeg_d       = ((op == 2'b01) || (op == 2'b10)) && rs1_val[W-1];
    bNeg_d       = (op == 2'b01) && rs2_val[W-1];
    aMag_d       = aNeg_d ? -rs1_val : rs1_val;
    bMag_d       = bNeg_d ? -rs2_val : rs2_val;
    neg_d        = aNeg_d ^ bNeg_d;
    prodStep_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
    prodSigned_d = neg_q ? -prod_q : prod_q;
  end

  // Control FSM, datapath registers and registered RegFile write-back outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      we3      <= 1'b0;
      ad3      <= '0;
      wd3      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            rd_q     <= rd_addr;
            neg_q    <= neg_d;
            mcand_q  <= {{W{1'b0}}, aMag_d};
            mplier_q <= bMag_d;
            prod_q   <= '0;
            count_q  <= CW'(W - 1);
            busy     <= 1'b1;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          prod_q   <= prodStep_d;
          mcand_q  <= {mcand_q[2*W-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[W-1:1]};
          if (count_q == '0) begin
            state_q <= FIN;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        FIN: begin
          wd3     <= (op_q == 2'b00) ? prodSigned_d[W-1:0] : prodSigned_d[2*W-1:W];
          ad3     <= rd_q;
          done    <= 1'b1;
          we3     <= (rd_q != '0);
          state_q <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          we3     <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          we3     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_writeback_unit.sv
// tb_mul_writeback_unit
// Directed and random operations against a plain-arithmetic reference of the
// four multiply flavours, with write-back timing checked cycle by cycle.
module tb_mul_writeback_unit;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  rs1Val;
  logic [W-1:0]  rs2Val;
  logic [AW-1:0] rdAddr;
  logic          busy;
  logic          done;
  logic          we3;
  logic [AW-1:0] ad3;
  logic [W-1:0]  wd3;

  int checks;
  int failures;
  int we3Total;
  int we3Expected;

  mul_writeback_unit #(.DATA_WIDTH(W), .ADDRESS_WIDTH(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_val (rs1Val),
    .rs2_val (rs2Val),
    .rd_addr (rdAddr),
    .busy    (busy),
    .done    (done),
    .we3     (we3),
    .ad3     (ad3),
    .wd3     (wd3)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every write-enable pulse seen on the falling edge.
  always @(negedge clk) begin
    if (we3 === 1'b1) we3Total++;
  end

  // Reference result: sign- or zero-extend each operand to 2W bits, multiply
  // modulo 2^(2W), and pick the low or high half.
  function automatic logic [W-1:0] refResult(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    logic [2*W-1:0] p;
    ea = ((o == 2'b01) || (o == 2'b10)) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = (o == 2'b01) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  // Operand chooser biased toward the corner values.
  function automatic logic [W-1:0] pickOperand();
    int sel;
    sel = int'($urandom_range(7));
    case (sel)
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return 32'd1;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full operation: accept, scramble the don't-care inputs, wait for done,
  // then check the result, the latency, the write enable and the return to idle.
  task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [AW-1:0] rd);
    logic [W-1:0]  expVal;
    logic [W-1:0]  wdCap;
    logic [AW-1:0] adCap;
    logic          weCap;
    int            doneAt;
    int            weSeen;
    expVal = refResult(o, a, b);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs1Val = a;
    rs2Val = b;
    rdAddr = rd;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op     = 2'($urandom_range(3));
    rs1Val = 32'($urandom);
    rs2Val = 32'($urandom);
    rdAddr = 5'($urandom_range(31));
    doneAt = 0;
    weSeen = 0;
    wdCap  = '0;
    adCap  = '0;
    weCap  = 1'b0;
    for (int n = 1; n <= W + 6 && doneAt == 0; n++) begin
      @(negedge clk);
      if (we3 === 1'b1) weSeen++;
      if (n == 1) checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
      if (done === 1'b1) begin
        doneAt = n;
        wdCap  = wd3;
        adCap  = ad3;
        weCap  = we3;
      end
    end
    checkOutput({tag, "_latency"}, 64'(doneAt), 64'(W + 2));
    checkOutput({tag, "_wd3"}, 64'(wdCap), 64'(expVal));
    checkOutput({tag, "_we3"}, 64'(weCap), 64'(rd != '0));
    checkOutput({tag, "_we3count"}, 64'(weSeen), 64'(rd != '0));
    if (rd != '0) checkOutput({tag, "_ad3"}, 64'(adCap), 64'(rd));
    @(negedge clk);
    checkOutput({tag, "_idle"}, 64'({busy, done, we3}), 64'd0);
  endtask

  initial begin
    int          seenPulses;
    logic [1:0]  o;
    logic [AW-1:0] rd;
    checks      = 0;
    failures    = 0;
    we3Total    = 0;
    we3Expected = 0;
    rst    = 1'b1;
    start  = 1'b0;
    op     = '0;
    rs1Val = '0;
    rs2Val = '0;
    rdAddr = '0;

    // Reset state.
    #2;
    checkOutput("reset_outputs", 64'({busy, done, we3, ad3, wd3}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic MUL and the signed/unsigned high-half corners.
    applyStimulus("mul_7x6", 2'b00, 32'd7, 32'd6, 5'd5);
    applyStimulus("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3);
    checkOutput("mulh_min_const", 64'(wd3), 64'h4000_0000);
    applyStimulus("mulhu_ones", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    checkOutput("mulhu_ones_const", 64'(wd3), 64'hFFFF_FFFE);
    applyStimulus("mulhsu_ones", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    checkOutput("mulhsu_ones_const", 64'(wd3), 64'hFFFF_FFFF);
    applyStimulus("mul_neg3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 5'd3);
    checkOutput("mul_neg3x5_const", 64'(wd3), 64'hFFFF_FFF1);

    // start held high during busy must not launch a second operation.
    @(negedge clk);
    start  = 1'b1;
    op     = 2'b00;
    rs1Val = 32'd2;
    rs2Val = 32'd3;
    rdAddr = 5'd7;
    @(posedge clk);
    #1;
    rs1Val = 32'd9;
    rs2Val = 32'd9;
    seenPulses = 0;
    for (int n = 1; n <= W + 2; n++) begin
      @(negedge clk);
      if (done === 1'b1) seenPulses++;
    end
    checkOutput("hold_done_at_end", 64'(done), 64'd1);
    checkOutput("hold_wd3", 64'(wd3), 64'd6);
    start = 1'b0;
    for (int n = 0; n < W + 6; n++) begin
      @(negedge clk);
      if (done === 1'b1) seenPulses++;
    end
    checkOutput("hold_single_done", 64'(seenPulses), 64'd1);

    // rd_addr=0 still completes but never writes.
    applyStimulus("mul_rd0", 2'b00, 32'd4, 32'd4, 5'd0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start  = 1'b1;
    op     = 2'b00;
    rs1Val = 32'd11;
    rs2Val = 32'd13;
    rdAddr = 5'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_outputs", 64'({busy, done, we3, ad3, wd3}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seenPulses = 0;
    for (int n = 0; n < W + 6; n++) begin
      @(negedge clk);
      if ((done === 1'b1) || (we3 === 1'b1)) seenPulses++;
    end
    checkOutput("abort_no_pulse", 64'(seenPulses), 64'd0);
    applyStimulus("after_abort", 2'b00, 32'd12, 32'd12, 5'd4);

    // Random operations across all op codes and corner operands.
    we3Total = 0;
    for (int i = 0; i < 1000; i++) begin
      o  = 2'($urandom_range(3));
      rd = 5'($urandom_range(31));
      if (rd != '0) we3Expected++;
      applyStimulus("rand", o, pickOperand(), pickOperand(), rd);
    end
    checkOutput("rand_we3_total", 64'(we3Total), 64'(we3Expected));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
